// File: rtl/adder_tree_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : adder_tree_scheduler
//  Purpose  : Sequences one shared combinational NUM_NODES-wide adder tree to
//             form a long fixed-point sum of NUM_NODES*NUM_CHUNKS terms (for
//             example an RBM neuron pre-activation). One chunk of operands is
//             read per cycle from a 1-cycle-latency memory, passed straight to
//             the tree, and the tree's partial sums are accumulated onto a
//             bias captured at job start.
//
//  Ports    :
//    clk          in   machine clock, rising-edge active
//    rst          in   asynchronous, active-high reset
//    start        in   job request, sampled only while idle
//    bias         in   accumulator seed, captured on an accepted start
//    busy         out  high while a job is running or completing
//    done         out  one-cycle pulse, result valid while high
//    result       out  final sum, held until the next accepted start
//    rd_en        out  memory read strobe
//    chunk_addr   out  chunk index being read
//    chunk_data   in   memory read data, valid the cycle after rd_en
//    tree_addends out  operands presented to the shared adder tree
//    tree_result  in   combinational tree sum of tree_addends
//
//  Revision : 1.0  initial release
// ============================================================================
module adder_tree_scheduler #(
    parameter int PRECISION_BITS = 32,
    parameter int NUM_NODES      = 4,
    parameter int NUM_CHUNKS     = 4,
    parameter int ADDR_BITS      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    parameter int RBM_CLOCK_FREQ = 50_000_000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [PRECISION_BITS-1:0]           bias,
    output logic                                busy,
    output logic                                done,
    output logic [PRECISION_BITS-1:0]           result,
    output logic                                rd_en,
    output logic [ADDR_BITS-1:0]                chunk_addr,
    input  logic [PRECISION_BITS*NUM_NODES-1:0] chunk_data,
    output logic [PRECISION_BITS*NUM_NODES-1:0] tree_addends,
    input  logic [PRECISION_BITS-1:0]           tree_result
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The issue counter runs from 0 up to NUM_CHUNKS inclusive, so it needs
    // one bit more than the chunk address.
    localparam int                    c_cnt_bits   = ADDR_BITS + 1;
    localparam logic [c_cnt_bits-1:0] c_num_chunks = c_cnt_bits'(NUM_CHUNKS);
    localparam logic [c_cnt_bits-1:0] c_cnt_one    = c_cnt_bits'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]                r_state;
    logic [1:0]                w_state_next;

    logic [PRECISION_BITS-1:0] r_acc;
    logic [PRECISION_BITS-1:0] r_result;
    logic                      r_rd_en;
    logic [ADDR_BITS-1:0]      r_chunk_addr;
    logic [c_cnt_bits-1:0]     r_issue_cnt;
    logic                      r_vld;

    logic                      w_accept;
    logic [c_cnt_bits-1:0]     w_next_cnt;
    logic                      w_more;
    logic                      w_last_chunk;
    logic [PRECISION_BITS-1:0] w_acc_sum;

    // ------------------------------------------------------------------------
    // Tree path: a pure pass-through, the block adds no latency here. The
    // clock frequency only documents the build, so both arms are identical.
    // ------------------------------------------------------------------------
    generate
        if (RBM_CLOCK_FREQ > 0) begin : g_tree_path
            assign tree_addends = chunk_data;
        end else begin : g_tree_path_nofreq
            assign tree_addends = chunk_data;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    assign w_accept   = (r_state == c_st_idle) && start;
    assign w_next_cnt = r_issue_cnt + c_cnt_one;
    assign w_more     = (w_next_cnt < c_num_chunks);

    // vld is rd_en delayed by one cycle, so the only cycle with vld high and
    // rd_en already low is the one carrying the final chunk's tree sum.
    assign w_last_chunk = r_vld && !r_rd_en;

    // Two's-complement wrap-around is intended; no saturation.
    assign w_acc_sum = r_acc + tree_result;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = c_st_run;
                end
            end
            c_st_run: begin
                if (w_last_chunk) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                // DONE lasts exactly one cycle; start is not looked at here.
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs, decoded from the registered state so they fall to zero
    // as soon as reset is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_st_run: begin
                busy = 1'b1;
            end
            c_st_done: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: read issue, accumulation and result capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_result     <= '0;
            r_rd_en      <= 1'b0;
            r_chunk_addr <= '0;
            r_issue_cnt  <= '0;
            r_vld        <= 1'b0;
        end else begin
            if (w_accept) begin
                // Seed the job; address 0 is presented in the first RUN cycle.
                r_acc        <= bias;
                r_issue_cnt  <= '0;
                r_rd_en      <= 1'b1;
                r_chunk_addr <= '0;
                r_vld        <= 1'b0;
            end else if (r_state == c_st_run) begin
                r_vld <= r_rd_en;

                if (r_rd_en) begin
                    // Each issued address is held for one cycle; after the
                    // last one the strobe drops and the address is left alone.
                    r_issue_cnt <= w_next_cnt;
                    r_rd_en     <= w_more;
                    if (w_more) begin
                        r_chunk_addr <= w_next_cnt[ADDR_BITS-1:0];
                    end
                end

                if (r_vld) begin
                    r_acc <= w_acc_sum;
                end

                if (w_last_chunk) begin
                    r_result <= w_acc_sum;
                end
            end
        end
    end

    assign result     = r_result;
    assign rd_en      = r_rd_en;
    assign chunk_addr = r_chunk_addr;

endmodule
`default_nettype wire
